// File: rtl/legv8_control_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/flags/memory-ready in, control word and immediate out.
interface legv8_control_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      IR_out;
  logic [4:0]       status;
  logic             mem_wait;
  logic [39:0]      ControlWord;
  logic [63:0]      constant;
  logic [2:0]       state_dbg;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  IR_out, status, mem_wait,
    output ControlWord, constant, state_dbg, halted, retired
  );

  modport slave (
    output IR_out, status, mem_wait,
    input  ControlWord, constant, state_dbg, halted, retired
  );
endinterface

// File: rtl/legv8_control_sequencer.sv
// Multi-cycle LEGv8 control sequencer: fetch/decode/execute/memory FSM producing the datapath
// control word and B-mux immediate, with memory stall and retired-instruction counting.
module legv8_control_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input logic                        clock,
  input logic                        reset,
  legv8_control_sequencer_if.master  bus
);

  localparam int unsigned REG_W   = 5;
  localparam int unsigned FS_W    = 5;
  localparam int unsigned CONST_W = 64;

  localparam logic [FS_W-1:0] FS_AND = 5'b00000;
  localparam logic [FS_W-1:0] FS_ORR = 5'b00100;
  localparam logic [FS_W-1:0] FS_ADD = 5'b01000;
  localparam logic [FS_W-1:0] FS_SUB = 5'b01001;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_OFFSET = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_WR    = 2'b01;
  localparam logic [1:0] MEM_FETCH = 2'b10;
  localparam logic [1:0] MEM_RD    = 2'b11;

  localparam logic [1:0] SIZE_64 = 2'b11;
  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI,
    C_B, C_CBZ, C_CBNZ, C_LDUR, C_STUR, C_ILL
  } iclass_t;

  typedef struct packed {
    logic [6:0]       rsvd;
    logic [1:0]       mem_op;
    logic [1:0]       ps;
    logic             pc_addr;
    logic             ir_load;
    logic             b_sel;
    logic             status_load;
    logic [FS_W-1:0]  fs;
    logic             c0;
    logic [1:0]       size;
    logic             mem_write;
    logic             reg_write;
    logic [REG_W-1:0] sb;
    logic [REG_W-1:0] sa;
    logic [REG_W-1:0] da;
  } cw_t;

  state_t           state, next_state;
  iclass_t          iclass;
  cw_t              cw;
  logic [CONST_W-1:0] konst;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  logic             halted_q;
  logic [31:0]      ir;
  logic             unused_status;

  assign ir            = bus.IR_out;
  assign unused_status = ^bus.status[4:1];

  // Instruction class from the opcode fields held in IR.
  always_comb begin
    iclass = C_ILL;
    if      (ir[31:21] == 11'b10001011000) iclass = C_ADD;
    else if (ir[31:21] == 11'b11001011000) iclass = C_SUB;
    else if (ir[31:21] == 11'b10001010000) iclass = C_AND;
    else if (ir[31:21] == 11'b10101010000) iclass = C_ORR;
    else if (ir[31:21] == 11'b11111000010) iclass = C_LDUR;
    else if (ir[31:21] == 11'b11111000000) iclass = C_STUR;
    else if (ir[31:22] == 10'b1001000100)  iclass = C_ADDI;
    else if (ir[31:22] == 10'b1101000100)  iclass = C_SUBI;
    else if (ir[31:24] == 8'b10110100)     iclass = C_CBZ;
    else if (ir[31:24] == 8'b10110101)     iclass = C_CBNZ;
    else if (ir[31:26] == 6'b000101)       iclass = C_B;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FETCH;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state    <= next_state;
      halted_q <= (next_state == S_HALT);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next state, control word and immediate for the current state and instruction.
  always_comb begin
    next_state = state;
    cw         = '0;
    konst      = '0;
    retire     = 1'b0;

    case (state)
      S_FETCH: begin
        cw.mem_op  = MEM_FETCH;
        cw.pc_addr = 1'b1;
        cw.ir_load = 1'b1;
        cw.size    = SIZE_64;
        if (!bus.mem_wait) begin
          cw.ps      = PS_INC;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        case (iclass)
          C_LDUR, C_STUR: next_state = S_MEM;
          C_ILL:          next_state = S_HALT;
          default:        next_state = S_EXEC;
        endcase
      end

      S_EXEC: begin
        next_state = S_FETCH;
        retire     = 1'b1;
        case (iclass)
          C_ADD, C_SUB, C_AND, C_ORR: begin
            cw.da        = ir[4:0];
            cw.sa        = ir[9:5];
            cw.sb        = ir[20:16];
            cw.reg_write = 1'b1;
            cw.c0        = (iclass == C_SUB);
            case (iclass)
              C_SUB:   cw.fs = FS_SUB;
              C_AND:   cw.fs = FS_AND;
              C_ORR:   cw.fs = FS_ORR;
              default: cw.fs = FS_ADD;
            endcase
          end
          C_ADDI, C_SUBI: begin
            cw.da        = ir[4:0];
            cw.sa        = ir[9:5];
            cw.b_sel     = 1'b1;
            cw.reg_write = 1'b1;
            cw.fs        = (iclass == C_SUBI) ? FS_SUB : FS_ADD;
            cw.c0        = (iclass == C_SUBI);
            konst        = {52'd0, ir[21:10]};
          end
          C_B: begin
            cw.ps = PS_OFFSET;
            konst = {{36{ir[25]}}, ir[25:0], 2'b00} - CONST_W'(4);
          end
          C_CBZ, C_CBNZ: begin
            // Zero test rides on the ALU passing Rt through (Rt + XZR).
            cw.sa = ir[4:0];
            cw.sb = XZR;
            cw.fs = FS_ADD;
            cw.ps = (bus.status[0] == (iclass == C_CBZ)) ? PS_OFFSET : PS_HOLD;
            konst = {{43{ir[23]}}, ir[23:5], 2'b00} - CONST_W'(4);
          end
          default: ;
        endcase
      end

      S_MEM: begin
        cw.sa    = ir[9:5];
        cw.b_sel = 1'b1;
        cw.fs    = FS_ADD;
        cw.size  = SIZE_64;
        konst    = {{55{ir[20]}}, ir[20:12]};
        if (iclass == C_STUR) begin
          cw.mem_op    = MEM_WR;
          cw.sb        = ir[4:0];
          cw.mem_write = !bus.mem_wait;
        end else begin
          cw.mem_op    = MEM_RD;
          cw.da        = ir[4:0];
          cw.reg_write = !bus.mem_wait;
        end
        if (!bus.mem_wait) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end

      S_HALT: next_state = S_HALT;

      default: next_state = S_FETCH;
    endcase

    // Reset cycle must never issue a write or a PC update.
    if (reset) begin
      cw    = '0;
      konst = '0;
    end
  end

  assign bus.ControlWord = cw;
  assign bus.constant    = konst;
  assign bus.state_dbg   = state;
  assign bus.halted      = halted_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_legv8_control_sequencer.sv
// Directed bench for legv8_control_sequencer: walks each instruction class through the FSM
// and compares control word, immediate, state, halt flag and retired count against hand values.
module tb_legv8_control_sequencer;

  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;

  legv8_control_sequencer_if bus ();

  legv8_control_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [39:0] CW_FETCH       = 40'h01_3806_0000;
  localparam logic [39:0] CW_FETCH_STALL = 40'h01_1806_0000;

  function automatic logic [39:0] mk_cw(
    input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
    input logic rw, input logic mw, input logic [1:0] sz, input logic c0,
    input logic [4:0] fs, input logic bsel, input logic [1:0] ps, input logic [1:0] mop);
    mk_cw = {7'd0, mop, ps, 1'b0, 1'b0, bsel, 1'b0, fs, c0, sz, mw, rw, sb, sa, da};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    bus.IR_out = 32'h8B03_0041;
    bus.status = 5'd0;
    bus.mem_wait = 1'b0;
    tick();
    tick();
    chk("rst_state", 64'(bus.state_dbg), 64'd0);
    chk("rst_cw", 64'(bus.ControlWord), 64'd0);
    chk("rst_const", bus.constant, 64'd0);
    chk("rst_retired", 64'(bus.retired), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);

    // ADD X1,X2,X3
    reset = 1'b0;
    #1;
    chk("add_fetch_cw", 64'(bus.ControlWord), 64'(CW_FETCH));
    tick();
    chk("add_decode_state", 64'(bus.state_dbg), 64'd1);
    chk("add_decode_cw", 64'(bus.ControlWord), 64'd0);
    tick();
    chk("add_exec_state", 64'(bus.state_dbg), 64'd2);
    chk("add_exec_cw", 64'(bus.ControlWord),
        64'(mk_cw(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 5'b01000, 1'b0, 2'b00, 2'b00)));
    chk("add_exec_retired", 64'(bus.retired), 64'd0);
    tick();
    chk("add_retired", 64'(bus.retired), 64'd1);
    chk("add_back_fetch", 64'(bus.state_dbg), 64'd0);

    // LDUR X2,[X31,#8], with a fetch stall and three memory wait cycles
    bus.IR_out = 32'hF840_83E2;
    bus.mem_wait = 1'b1;
    #1;
    chk("fetch_stall_cw", 64'(bus.ControlWord), 64'(CW_FETCH_STALL));
    tick();
    chk("fetch_stall_state", 64'(bus.state_dbg), 64'd0);
    bus.mem_wait = 1'b0;
    #1;
    chk("ldur_fetch_cw", 64'(bus.ControlWord), 64'(CW_FETCH));
    tick();
    bus.mem_wait = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ldur_wait_state", 64'(bus.state_dbg), 64'd3);
      chk("ldur_wait_cw", 64'(bus.ControlWord),
          64'(mk_cw(5'd2, 5'd31, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0, 5'b01000, 1'b1, 2'b00, 2'b11)));
      chk("ldur_wait_retired", 64'(bus.retired), 64'd1);
      if (i < 2) tick();
    end
    bus.mem_wait = 1'b0;
    #1;
    chk("ldur_go_cw", 64'(bus.ControlWord),
        64'(mk_cw(5'd2, 5'd31, 5'd0, 1'b1, 1'b0, 2'b11, 1'b0, 5'b01000, 1'b1, 2'b00, 2'b11)));
    chk("ldur_const", bus.constant, 64'd8);
    tick();
    chk("ldur_retired", 64'(bus.retired), 64'd2);
    chk("ldur_back_fetch", 64'(bus.state_dbg), 64'd0);

    // STUR X5,[X3,#-8]
    bus.IR_out = 32'hF81F_8065;
    tick();
    tick();
    chk("stur_state", 64'(bus.state_dbg), 64'd3);
    chk("stur_cw", 64'(bus.ControlWord),
        64'(mk_cw(5'd0, 5'd3, 5'd5, 1'b0, 1'b1, 2'b11, 1'b0, 5'b01000, 1'b1, 2'b00, 2'b01)));
    chk("stur_const", bus.constant, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("stur_retired", 64'(bus.retired), 64'd3);

    // CBZ X4,#3: taken then not taken
    bus.IR_out = 32'hB400_0064;
    bus.status = 5'b00001;
    tick();
    tick();
    chk("cbz_taken_cw", 64'(bus.ControlWord),
        64'(mk_cw(5'd0, 5'd4, 5'd31, 1'b0, 1'b0, 2'b00, 1'b0, 5'b01000, 1'b0, 2'b11, 2'b00)));
    chk("cbz_const", bus.constant, 64'd8);
    bus.status = 5'b00000;
    #1;
    chk("cbz_not_taken_cw", 64'(bus.ControlWord),
        64'(mk_cw(5'd0, 5'd4, 5'd31, 1'b0, 1'b0, 2'b00, 1'b0, 5'b01000, 1'b0, 2'b00, 2'b00)));
    tick();
    chk("cbz_retired", 64'(bus.retired), 64'd4);

    // CBNZ X4,#3 with zero flag clear -> taken
    bus.IR_out = 32'hB500_0064;
    tick();
    tick();
    chk("cbnz_taken_ps", 64'(bus.ControlWord[30:29]), 64'd3);
    bus.status = 5'b00001;
    #1;
    chk("cbnz_not_taken_ps", 64'(bus.ControlWord[30:29]), 64'd0);
    tick();

    // B #-1
    bus.IR_out = 32'h17FF_FFFF;
    tick();
    tick();
    chk("b_cw", 64'(bus.ControlWord), 64'h00_6000_0000);
    chk("b_const", bus.constant, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("b_retired", 64'(bus.retired), 64'd6);

    // ADDI X7,X8,#4095
    bus.IR_out = 32'h913F_FD07;
    tick();
    tick();
    chk("addi_cw", 64'(bus.ControlWord),
        64'(mk_cw(5'd7, 5'd8, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 5'b01000, 1'b1, 2'b00, 2'b00)));
    chk("addi_const", bus.constant, 64'h0000_0000_0000_0FFF);
    tick();

    // SUB X1,X2,X3
    bus.IR_out = 32'hCB03_0041;
    tick();
    tick();
    chk("sub_cw", 64'(bus.ControlWord),
        64'(mk_cw(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 2'b00, 1'b1, 5'b01001, 1'b0, 2'b00, 2'b00)));
    tick();
    chk("sub_retired", 64'(bus.retired), 64'd8);

    // Illegal opcode parks the sequencer
    bus.IR_out = 32'hFFFF_FFFF;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", 64'(bus.state_dbg), 64'd4);
      chk("halt_flag", 64'(bus.halted), 64'd1);
      chk("halt_cw", 64'(bus.ControlWord), 64'd0);
      tick();
    end
    chk("halt_retired", 64'(bus.retired), 64'd8);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("unhalt_flag", 64'(bus.halted), 64'd0);
    chk("unhalt_state", 64'(bus.state_dbg), 64'd0);

    // One ADD retires, the next is abandoned by reset in EXEC
    bus.IR_out = 32'h8B03_0041;
    tick();
    tick();
    tick();
    chk("pre_abort_retired", 64'(bus.retired), 64'd1);
    tick();
    tick();
    chk("abort_exec_state", 64'(bus.state_dbg), 64'd2);
    reset = 1'b1;
    #1;
    chk("abort_cw", 64'(bus.ControlWord), 64'd0);
    chk("abort_const", bus.constant, 64'd0);
    tick();
    chk("abort_state", 64'(bus.state_dbg), 64'd0);
    chk("abort_retired", 64'(bus.retired), 64'd0);
    chk("abort_halted", 64'(bus.halted), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
